// File: rtl/clk_divider_prog.sv
// clk_divider_prog: multi-channel, run-time programmable clock/tick divider.
// Each channel counts 0..div-1 on CLK_IN. In clock mode it drives a
// registered near-50% CLK_OUT (low ceil(div/2), high floor(div/2)); in tick
// mode it drives a one-cycle TICK after every period. New configuration goes
// into a per-channel shadow register and becomes active only at a period
// boundary, or at once while the channel is disabled. Because of this, no
// output phase is ever cut short.
// Ports:
//   CLK_IN   system clock, rising edge
//   RST_N    asynchronous active-low reset
//   EN       per-channel run enable
//   CFG_WE   configuration write strobe (one cycle per write)
//   CFG_CH   target channel of the write
//   CFG_DIV  new divisor (full period in CLK_IN cycles, >= 2)
//   CFG_MODE new mode (0 = clock, 1 = tick)
//   CFG_ERR  one-cycle pulse after a rejected write
//   PENDING  per-channel shadow config waiting for its apply point
//   CLK_OUT  per-channel divided clock (mode 0)
//   TICK     per-channel one-cycle period pulse (mode 1)
module clk_divider_prog #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_DIV  = 5000,
  parameter bit          DEFAULT_MODE = 1'b0,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_IN,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [WIDTH-1:0]  CFG_DIV,
  input  logic              CFG_MODE,
  output logic              CFG_ERR,
  output logic [NUM_CH-1:0] PENDING,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] TICK
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("clk_divider_prog: NUM_CH must be in 1..8");
  end
  if (DEFAULT_DIV < 2 || 64'(DEFAULT_DIV) >= (64'd1 << WIDTH)) begin : g_bad_default_div
    $error("clk_divider_prog: DEFAULT_DIV must satisfy 2 <= DEFAULT_DIV < 2**WIDTH");
  end

  logic wr_valid;

  always_comb begin
    wr_valid = (CFG_DIV >= WIDTH'(2)) && (32'(CFG_CH) < NUM_CH);
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      CFG_ERR <= 1'b0;
    end else begin
      CFG_ERR <= CFG_WE && !wr_valid;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_sh;
    logic             mode_act;
    logic             mode_sh;
    logic             pend;
    logic             clk_q;
    logic             tick_q;
    logic [WIDTH:0]   half;
    logic             boundary;
    logic             rise;
    logic             apply;
    logic             wr_hit;

    always_comb begin
      // ceil(div/2) needs the extra bit so div = 2**WIDTH-1 does not wrap
      half     = ({1'b0, div_act} + (WIDTH+1)'(1)) >> 1;
      boundary = (count == div_act - WIDTH'(1));
      rise     = ({1'b0, count} == half - (WIDTH+1)'(1));
      apply    = !EN[g] || boundary;
      wr_hit   = CFG_WE && wr_valid && (CFG_CH == CH_W'(g));
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
        count    <= '0;
        div_act  <= WIDTH'(DEFAULT_DIV);
        mode_act <= DEFAULT_MODE;
        div_sh   <= WIDTH'(DEFAULT_DIV);
        mode_sh  <= DEFAULT_MODE;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        if (wr_hit) begin
          div_sh  <= CFG_DIV;
          mode_sh <= CFG_MODE;
        end

        // A write landing on the apply cycle bypasses the shadow.
        if (apply) begin
          if (wr_hit) begin
            div_act  <= CFG_DIV;
            mode_act <= CFG_MODE;
            pend     <= 1'b0;
          end else if (pend) begin
            div_act  <= div_sh;
            mode_act <= mode_sh;
            pend     <= 1'b0;
          end
        end else if (wr_hit) begin
          pend <= 1'b1;
        end

        if (!EN[g]) begin
          count  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (boundary) begin
          // The tick marks the end of the period under the mode that produced it.
          count  <= '0;
          clk_q  <= 1'b0;
          tick_q <= mode_act;
        end else begin
          count  <= count + WIDTH'(1);
          tick_q <= 1'b0;
          if (rise && !mode_act) begin
            clk_q <= 1'b1;
          end
        end
      end
    end

    assign PENDING[g] = pend;
    assign CLK_OUT[g] = clk_q;
    assign TICK[g]    = tick_q;
  end

endmodule
